// File: rtl/stopwatch_counter.sv
// BCD minutes:seconds core for the lab3 stopwatch: counts on the 1 Hz tick,
// supports run/pause, and adjusts a selected field on the 2 Hz tick.
module stopwatch_counter #(
  parameter int unsigned MAX_VAL = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       counter_tick,
  input  logic       adj_tick,
  input  logic       pause_pulse,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       paused,
  output logic       wrap,
  output logic [1:0] fsm_state
);

  localparam logic [3:0] MAX_T = 4'(MAX_VAL / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_VAL % 10);

  // Encoding is {adjust, hold}; pause and adjust are orthogonal bits.
  typedef enum logic [1:0] {
    RUN         = 2'b00,
    HOLD        = 2'b01,
    ADJUST_RUN  = 2'b10,
    ADJUST_HOLD = 2'b11
  } state_t;

  state_t state;
  state_t state_next;

  logic count_en;
  logic adjust_en;
  logic sec_max;
  logic min_max;

  function automatic logic [7:0] field_inc(input logic [3:0] t, input logic [3:0] o);
    logic [7:0] r;
    if (t == MAX_T && o == MAX_O) r = 8'h00;
    else if (o == 4'd9)           r = {t + 4'd1, 4'd0};
    else                          r = {t, o + 4'd1};
    return r;
  endfunction

  // The adj level takes effect in the same cycle it rises, so a coincident
  // counter_tick is suppressed and an adj_tick already adjusts.
  always_comb begin
    count_en   = counter_tick && (state == RUN) && !adj;
    adjust_en  = adj_tick && (adj || state[1]);
    sec_max    = (sec_tens == MAX_T) && (sec_ones == MAX_O);
    min_max    = (min_tens == MAX_T) && (min_ones == MAX_O);
    state_next = state_t'({adj, state[0] ^ pause_pulse});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      paused   <= 1'b0;
      wrap     <= 1'b0;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
    end else begin
      state  <= state_next;
      paused <= state_next[0];
      wrap   <= count_en && sec_max && min_max;
      if (adjust_en) begin
        if (sel) {sec_tens, sec_ones} <= field_inc(sec_tens, sec_ones);
        else     {min_tens, min_ones} <= field_inc(min_tens, min_ones);
      end else if (count_en) begin
        {sec_tens, sec_ones} <= field_inc(sec_tens, sec_ones);
        if (sec_max) {min_tens, min_ones} <= field_inc(min_tens, min_ones);
      end
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: an integer model pushes expected
// {digits, paused, wrap, state} per step; each is popped after the clock edge.
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       counter_tick = 1'b0;
  logic       adj_tick = 1'b0;
  logic       pause_pulse = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       paused, wrap;
  logic [1:0] fsm_state;

  int vectors = 0;
  int miscompares = 0;
  logic [19:0] exp_q[$];

  int m_min = 0;
  int m_sec = 0;
  bit m_hold = 1'b0;
  bit m_adj = 1'b0;
  bit m_wrap = 1'b0;

  stopwatch_counter #(.MAX_VAL(59)) dut (
    .clk(clk), .rst(rst), .counter_tick(counter_tick), .adj_tick(adj_tick),
    .pause_pulse(pause_pulse), .adj(adj), .sel(sel),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .paused(paused), .wrap(wrap), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] model_vec();
    return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
            m_hold, m_wrap, m_adj, m_hold};
  endfunction

  task automatic compare(input string tag);
    logic [19:0] obs;
    logic [19:0] exp;
    obs = {min_tens, min_ones, sec_tens, sec_ones, paused, wrap, fsm_state};
    exp = exp_q.pop_front();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_now(input string tag);
    exp_q.push_back(model_vec());
    compare(tag);
  endtask

  task automatic step(input bit ct_i, input bit at_i, input bit pp_i,
                      input bit a_i, input bit sl_i, input string tag);
    bit do_cnt;
    bit do_adj;
    @(negedge clk);
    counter_tick = ct_i;
    adj_tick     = at_i;
    pause_pulse  = pp_i;
    adj          = a_i;
    sel          = sl_i;
    do_cnt = ct_i && !m_adj && !m_hold && !a_i;
    do_adj = at_i && (a_i || m_adj);
    m_wrap = 1'b0;
    if (do_adj) begin
      if (sl_i) m_sec = (m_sec == 59) ? 0 : m_sec + 1;
      else      m_min = (m_min == 59) ? 0 : m_min + 1;
    end else if (do_cnt) begin
      if (m_sec == 59) begin
        m_sec = 0;
        if (m_min == 59) begin
          m_min  = 0;
          m_wrap = 1'b1;
        end else begin
          m_min = m_min + 1;
        end
      end else begin
        m_sec = m_sec + 1;
      end
    end
    m_hold = m_hold ^ pp_i;
    m_adj  = a_i;
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    compare(tag);
    counter_tick = 1'b0;
    adj_tick     = 1'b0;
    pause_pulse  = 1'b0;
  endtask

  initial begin
    // Reset and basic count
    #12;
    check_now("reset_state");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, "count_to_5");
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, "count_to_10");

    // Pause holds the count; resume continues
    step(0, 0, 1, 0, 0, "pause_enter");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, "hold_ignores_tick");
    step(0, 0, 1, 0, 0, "pause_exit");
    step(1, 0, 0, 0, 0, "resume_count");

    // Pause together with tick: count then hold
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0, "count_to_20");
    step(1, 0, 1, 0, 0, "pause_with_tick");
    step(1, 0, 0, 0, 0, "held_after_combo");
    step(0, 0, 1, 0, 0, "resume_again");

    // Seconds carry, then full-scale rollover
    for (int i = 0; i < 38; i++) step(1, 0, 0, 0, 0, "count_to_59");
    step(1, 0, 0, 0, 0, "sec_carry");
    for (int i = 0; i < 3539; i++) step(1, 0, 0, 0, 0, "run_to_5959");
    step(1, 0, 0, 0, 0, "full_wrap");
    step(0, 0, 0, 0, 0, "wrap_one_cycle");

    // Adjust minutes from 58:30 with interleaved counter ticks
    for (int i = 0; i < 58; i++) step(0, 1, 0, 1, 0, "adj_min_setup");
    for (int i = 0; i < 30; i++) step(0, 1, 0, 1, 1, "adj_sec_setup");
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, 0, "adj_ignores_tick");
      step(0, 1, 0, 1, 0, "adj_min_wrap");
    end
    step(1, 1, 0, 1, 0, "adj_tick_beats_count");

    // Adjust seconds from 00:58
    for (int i = 0; i < 58; i++) step(0, 1, 0, 1, 0, "adj_min_to_0");
    for (int i = 0; i < 28; i++) step(0, 1, 0, 1, 1, "adj_sec_to_58");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 1, "adj_sec_wrap");

    // Build 12:34 in ADJUST_HOLD, then reset between edges
    for (int i = 0; i < 12; i++) step(0, 1, 0, 1, 0, "adj_min_12");
    for (int i = 0; i < 33; i++) step(0, 1, 0, 1, 1, "adj_sec_34");
    step(0, 0, 1, 1, 1, "adjust_hold_enter");
    step(0, 1, 0, 1, 1, "adj_in_hold");
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    m_min = 0; m_sec = 0; m_hold = 1'b0; m_adj = 1'b0; m_wrap = 1'b0;
    check_now("async_reset");
    adj = 1'b0;
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 0, 0, 0, "count_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
